// File: rtl/weight_buffer_ctrl_pkg.sv
// Shared configuration and types for the weight-buffer sequencer.
// Default array geometry and the state encoding used by weight_buffer_ctrl.
package weight_buffer_ctrl_pkg;

  localparam int sys_cols       = 4;
  localparam int w_bitwidth     = 8;
  localparam int w_buffer_depth = 16;

  localparam int WCTRL_CNT_W = $clog2(w_buffer_depth + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } wctrl_state_e;

endpackage

// File: rtl/wctrl_counter.sv
// Up-counter with synchronous clear, parallel load, enable and a terminal-value compare.
module wctrl_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/weight_buffer_ctrl.sv
// Per-tile sequencer for the column weight FIFO bank: load K rows, burst K reads,
// wait out the column skew, then pulse done.
module weight_buffer_ctrl
  import weight_buffer_ctrl_pkg::*;
#(
  parameter int SYS_COLS   = sys_cols,
  parameter int W_BITWIDTH = w_bitwidth,
  parameter int DEPTH      = w_buffer_depth,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 cfg_k,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [SYS_COLS*W_BITWIDTH-1:0]   s_data,
  output logic [SYS_COLS-1:0]              wb_wr_en,
  output logic [SYS_COLS*W_BITWIDTH-1:0]   wb_i_data,
  output logic                             wb_read,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int DR_W = (SYS_COLS > 2) ? $clog2(SYS_COLS) : 1;
  localparam logic [DR_W-1:0] DR_TERM = DR_W'((SYS_COLS > 1) ? SYS_COLS - 2 : 0);

  wctrl_state_e     state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] k_last;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [DR_W-1:0]  dr_cnt;
  logic             beat;
  logic             beat_tc;
  logic             rd_tc;
  logic             dr_tc;

  assign beat      = s_valid & s_ready;
  assign wb_wr_en  = {SYS_COLS{beat}};
  assign wb_i_data = s_data;
  // k >= 1 whenever LOAD/STREAM are live, so k-1 never underflows there.
  assign k_last    = k - CNT_W'(1);

  wctrl_counter #(.W(CNT_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != LOAD),
    .en       (beat),
    .load     (1'b0),
    .load_val ('0),
    .term     (k_last),
    .count    (beat_cnt),
    .at_term  (beat_tc)
  );

  wctrl_counter #(.W(CNT_W)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != STREAM),
    .en       (state == STREAM),
    .load     (1'b0),
    .load_val ('0),
    .term     (k_last),
    .count    (rd_cnt),
    .at_term  (rd_tc)
  );

  wctrl_counter #(.W(DR_W)) u_dr_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != DRAIN),
    .en       (state == DRAIN),
    .load     (1'b0),
    .load_val ('0),
    .term     (DR_TERM),
    .count    (dr_cnt),
    .at_term  (dr_tc)
  );

  // Outputs are registered alongside the state so they decode the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      s_ready <= 1'b0;
      wb_read <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_k == '0) begin
              state <= DONE;
              busy  <= 1'b1;
              done  <= 1'b1;
            end else if (cfg_k > CNT_W'(DEPTH)) begin
              err <= 1'b1;
            end else begin
              k       <= cfg_k;
              state   <= LOAD;
              busy    <= 1'b1;
              s_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat && beat_tc) begin
            state   <= STREAM;
            s_ready <= 1'b0;
            wb_read <= 1'b1;
          end
        end
        STREAM: begin
          if (rd_tc) begin
            wb_read <= 1'b0;
            if (SYS_COLS == 1) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (dr_tc) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          wb_read <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/weight_buffer_ctrl.md
Name: weight_buffer_ctrl

Overview:
Sequencer for the per-column weight FIFO bank that feeds the systolic array. For each tile it:
- accepts K weight rows from the memory-side stream (valid/ready), writing every row into all column FIFOs in parallel;
- issues a K-cycle read burst into the weight FIFO bank;
- waits for the column-skewed read valids to drain, then signals done.

It sits between the DMA/weight-fetch path and the weight FIFO bank, under the top-level tile controller.

Parameters:
SYS_COLS, sys_cols (Config), number of array columns / weight FIFOs
W_BITWIDTH, W_BITWIDTH (Config), bits per weight
DEPTH, w_buffer_depth (Config), entries per column FIFO
CNT_W, $clog2(DEPTH+1), width of row/beat counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a tile; sampled only in IDLE
cfg_k  in  CNT_W  weight rows in this tile; latched on accepted start
s_valid  in  1  weight row valid from fetch path
s_ready  out  1  ctrl accepts a weight row
s_data  in  SYS_COLS*W_BITWIDTH  one weight row, column c at bits [c*W_BITWIDTH +: W_BITWIDTH]
wb_wr_en  out  SYS_COLS  per-column FIFO write enable
wb_i_data  out  SYS_COLS*W_BITWIDTH  FIFO write data
wb_read  out  1  read strobe to FIFO bank (column 0; bank skews the rest)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at tile completion
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: state=IDLE; all counters 0; s_ready, wb_wr_en, wb_read, busy, done and err are 0. A reset mid-operation aborts the tile immediately and raises no done. The FIFO bank shares rst, so its contents are also cleared.
- States: IDLE, LOAD, STREAM, DRAIN, DONE. All outputs are registered-state decodes except wb_wr_en and wb_i_data.
- IDLE, start=1, 1<=cfg_k<=DEPTH: latch k=cfg_k, clear beat counter, go to LOAD.
- IDLE, start=1, cfg_k=0: go to DONE. Done pulses the next cycle with no FIFO activity.
- IDLE, start=1, cfg_k>DEPTH: err=1 for one cycle; stay IDLE.
- Start while not in IDLE is ignored.
- LOAD:
  - s_ready=1.
  - Beat = s_valid & s_ready. On a beat: wb_wr_en = all ones, and the beat counter increments.
  - wb_i_data = s_data combinationally in all states, and is qualified by wb_wr_en.
  - When the beat count reaches k (on the k-th beat), go to STREAM the following cycle.
  - s_valid gaps stall LOAD indefinitely; no timeout.
- STREAM:
  - wb_read=1 for exactly k consecutive cycles, counted by the read counter.
  - s_ready=0 and wb_wr_en=0.
  - After the k-th cycle, go to DRAIN, or to DONE if SYS_COLS=1.
- DRAIN: wb_read=0 for exactly SYS_COLS-1 cycles, matching the one-cycle-per-column valid skew in the bank. Then go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. A start in the IDLE cycle after DONE is accepted, giving back-to-back tiles.
- Latency: start accepted at cycle t with no s_valid gaps.
  - LOAD occupies t+1 .. t+k.
  - STREAM occupies t+k+1 .. t+2k.
  - DRAIN occupies t+2k+1 .. t+2k+SYS_COLS-1.
  - done is high at t+2k+SYS_COLS.
- Counters are CNT_W wide. k<=DEPTH guarantees no FIFO overflow and no counter wrap. The ctrl never writes and reads the bank in the same cycle.

Decomposition:
- Config package gains typedef enum logic [2:0] wctrl_state_e {IDLE, LOAD, STREAM, DRAIN, DONE}.
- Config package gains localparam WCTRL_CNT_W = $clog2(w_buffer_depth+1).
- Natural sub-module: wctrl_counter, a loadable up-counter with clear, enable and terminal-compare output. It is instantiated three times: beat count, read count, drain count.
- The FSM stays in weight_buffer_ctrl.

Test Plan:
All scenarios use SYS_COLS=4, DEPTH=16.
1. start at cycle 0, cfg_k=3, s_valid held 1 -> s_ready=1 cycles 1-3; wb_wr_en=4'b1111 cycles 1-3; wb_read=1 cycles 4-6; done=1 at cycle 10; busy=1 cycles 1-10.
2. cfg_k=3, s_valid pattern 1,0,0,1,1 from cycle 1 -> wb_wr_en only on valid cycles 1, 4, 5; wb_read cycles 6-8; done at cycle 12.
3. start with cfg_k=0 at cycle 0 -> done=1 at cycle 1; wb_wr_en and wb_read stay 0.
4. start with cfg_k=17 -> err=1 the following cycle; busy stays 0; s_ready stays 0.
5. cfg_k=16, rst asserted during STREAM (third read cycle) -> next cycle IDLE, all outputs 0, no done. A new start with cfg_k=2 then completes normally, with done 2+2+3+1 cycles after start.
6. start held high continuously, cfg_k=1 -> tiles run back-to-back: done at cycle 6, next tile accepted at cycle 7, second done at cycle 13. Starts issued during busy have no effect.
